// File: rtl/dmem_access_unit.sv
// dmem_access_unit: byte/half/word load-store initiator with read-modify-write for sub-word stores
module dmem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] DMemAddr,
  output logic [31:0]       DMemWData,
  output logic              DMemR,
  output logic              DMemW,
  input  logic [31:0]       DMemRData
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dw_q, dw_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_err;
  logic [31:0]       rd_shift;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_val;
  logic [31:0]       bmask;
  logic [31:0]       wsh;
  logic [31:0]       merged;
  always_comb begin
    req_err  = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
               (req_size == 2'b10 & |req_addr[1:0]) | |req_addr[31:ADDR_W+2];
    rd_shift = DMemRData >> {lane_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = lane_q[1] ? DMemRData[31:16] : DMemRData[15:0];
    ld_val   = size_q == 2'b00 ? {{24{sgn_q & rd_byte[7]}}, rd_byte} :
               size_q == 2'b01 ? {{16{sgn_q & rd_half[15]}}, rd_half} : DMemRData;
    bmask    = size_q == 2'b00 ? 32'h0000_00ff << {lane_q, 3'b000} : 32'h0000_ffff << {lane_q[1], 4'b0000};
    wsh      = size_q == 2'b00 ? wdata_q << {lane_q, 3'b000} : wdata_q << {lane_q[1], 4'b0000};
    merged   = (DMemRData & ~bmask) | (wsh & bmask);
  end
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    lane_d  = lane_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    dw_d    = dw_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        size_d  = req_size;
        lane_d  = req_addr[1:0];
        sgn_d   = req_signed;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = req_err;
        if (req_err) begin
          state_d = RESP;
        end else begin
          addr_d  = req_addr[ADDR_W+1:2];
          dw_d    = (req_write && req_size == 2'b10) ? req_wdata : dw_q;
          state_d = (req_write && req_size == 2'b10) ? WRITE : READ;
        end
      end
      READ: begin
        dw_d    = write_q ? merged : dw_q;
        rdata_d = write_q ? rdata_q : ld_val;
        state_d = write_q ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      dw_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      dw_q    <= dw_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign DMemAddr   = addr_q;
  assign DMemWData  = dw_q;
  assign DMemR      = (state_q == READ) & ~rst;
  assign DMemW      = (state_q == WRITE) & ~rst;
endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store initiator sitting between the CPU memory stage and the 32-word data memory. Accepts one byte/halfword/word load or store per request over a valid/ready handshake. Translates it into word-granular DMemR/DMemW accesses; sub-word stores use a read-modify-write. Returns zero- or sign-extended load data, or an error flag, over a valid/ready response channel.

## Interface
- ADDR_W, 5, word-address width of the data memory (depth = 2^ADDR_W words)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit accepts a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend loads (ignored for stores and word loads)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal-size request
- DMemAddr  out  ADDR_W  word address to data memory
- DMemWData  out  32  write word to data memory
- DMemR  out  1  read strobe
- DMemW  out  1  write strobe; memory commits on the falling clk edge of the cycle it is high
- DMemRData  in  32  combinational read word from data memory

## Operation
- Byte lane = req_addr[1:0], little-endian (lane 0 = bits [7:0]); word index = req_addr[ADDR_W+1:2].
- Error: req_size=11; half with addr[0]=1; word with addr[1:0]≠0; any bit of req_addr[31:ADDR_W+2] set. Errored requests make no memory access.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch all request fields.
  - error -> RESP (err=1)
  - word store -> WRITE
  - otherwise -> READ
- READ: DMemR=1, DMemAddr=latched index. At posedge capture DMemRData.
  - load: extract lane(s), extend per req_signed, -> RESP
  - sub-word store: merge req_wdata into the captured word at the lane(s), -> WRITE
- WRITE: DMemW=1, DMemWData = merged word (or req_wdata for word stores), -> RESP.
- RESP: resp_valid=1, with resp_rdata/resp_err stable. On resp_ready -> IDLE.
- req_ready=0 outside IDLE. No request is accepted in the cycle a response is consumed.
- Halfword lane = addr[1] (0 -> [15:0], 1 -> [31:16]). Zero-extension fills upper bits with 0; sign-extension replicates bit 7 (byte) or bit 15 (half).
- DMemAddr/DMemWData are registered and held stable through READ/WRITE. DMemR/DMemW are decoded from state.
- DMemW = (state==WRITE) & ~rst. A reset in the WRITE cycle suppresses the write.

## Timing
- Reset (synchronous): state IDLE, DMemR=0, DMemW=0, DMemAddr=0, DMemWData=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 from the first cycle after rst deasserts.
- Request accepted at edge T. resp_valid rises at:
  - T+1 for errors
  - T+2 for loads and word stores
  - T+3 for sub-word stores
- Minimum throughput: one request per 3 cycles (word), 4 (sub-word store), plus any resp_ready stall.
- resp_valid held with stable data until resp_ready is high at a posedge.
- Reset mid-operation: abort to IDLE at that edge. No partial write. The pending response is discarded.

## Test plan
- Word store 0xDEADBEEF to addr 0x10 (word index 4) -> DMemW high for exactly one cycle with DMemAddr=4; then word load from 0x10 -> resp_rdata=0xDEADBEEF, latency 2, resp_err=0.
- Memory word 4 = 0x11223344; signed byte load 0x13 -> 0x00000011; byte store 0xAA to 0x12 -> DMemR cycle then DMemW with DMemWData=0x11AA3344.
- Memory word 5 = 0x8000F0FF; signed half load 0x16 -> 0xFFFF8000; unsigned half load 0x14 -> 0x0000F0FF; signed byte load 0x14 -> 0xFFFFFFFF.
- Word load 0x02, half store 0x01, req_size=11, and address 0x80 -> resp_err=1 at T+1, DMemR=DMemW=0 throughout, resp_rdata=0.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0 throughout; releasing resp_ready returns to IDLE and the next request is accepted one cycle later.
- Assert rst during the WRITE cycle of a byte store -> DMemW=0 in that cycle, memory unchanged, all outputs at reset values the next cycle.
